addr_burst_issue: RTL and testbench

- Downstream consumer of the 16-bit address-calculation result (count).
- Buffers computed base addresses, each with a burst length, in a small FIFO.
- Expands each entry into a sequence of beat addresses on a valid/ready request port toward the memory interface.
- Decouples the combinational address path from memory back-pressure.

---
 rtl/addr_burst_issue.sv | 141 ++++++++++++++
 tb/tb_addr_burst_issue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_burst_issue.sv
// Burst address issuer: buffers {base address, length} entries in a small FIFO and
// expands each one into a stream of beat addresses on a valid/ready request port.
module addr_burst_issue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned STRIDE = 1,
    parameter int unsigned LW     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_addr,
    input  logic [LW-1:0]            in_len,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_addr,
    output logic                     out_last,
    output logic                     out_wrap,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];
    localparam logic [16:0] STRIDE_X   = {1'b0, STRIDE[15:0]};

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     cur_addr_q, cur_addr_d;
    logic [LW-1:0]   beats_left_q, beats_left_d;
    logic            last_q, last_d;
    logic            wrapped_q, wrapped_d;
    logic [AW:0]     level_q, level_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;

    logic [15:0]     addr_mem_q [DEPTH];
    logic [LW-1:0]   len_mem_q  [DEPTH];

    logic            push;
    logic            pop;
    logic            have_head;
    logic [16:0]     sum;

    // NOTE: storage carries no reset; level/pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= in_addr;
            len_mem_q[wr_ptr_q]  <= in_len;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            last_q       <= 1'b0;
            wrapped_q    <= 1'b0;
            level_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            last_q       <= last_d;
            wrapped_q    <= wrapped_d;
            level_q      <= level_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        last_d       = last_q;
        wrapped_d    = wrapped_q;
        pop          = 1'b0;
        in_ready     = (level_q < FULL_LEVEL);
        push         = in_valid && in_ready;
        have_head    = (level_q != '0);
        sum          = {1'b0, cur_addr_q} + STRIDE_X;

        unique case (state_q)
            S_IDLE: begin
                if (have_head) begin
                    pop     = 1'b1;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (out_ready) begin
                    if (!last_q) begin
                        cur_addr_d   = sum[15:0];
                        beats_left_d = beats_left_q - LW'(1);
                        last_d       = (beats_left_q == LW'(1));
                        wrapped_d    = wrapped_q | sum[16];
                    end else if (have_head) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Loading the head shares the edge with the final handshake, so bursts run back to back.
        if (pop) begin
            cur_addr_d   = addr_mem_q[rd_ptr_q];
            beats_left_d = len_mem_q[rd_ptr_q];
            last_d       = (len_mem_q[rd_ptr_q] == '0);
            wrapped_d    = 1'b0;
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        out_valid = (state_q == S_BURST);
        out_addr  = cur_addr_q;
        out_last  = last_q;
        out_wrap  = wrapped_q;
        level     = level_q;
    end

endmodule

// File: tb/tb_addr_burst_issue.sv
// Self-checking bench for addr_burst_issue: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based burst-expansion model.
module tb_addr_burst_issue;

    localparam int DEPTH  = 4;
    localparam int STRIDE = 1;
    localparam int LW     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_addr;
    logic [LW-1:0] in_len;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_addr;
    logic          out_last;
    logic          out_wrap;
    logic [2:0]    level;

    always #5 clk = ~clk;

    addr_burst_issue #(
        .DEPTH  (DEPTH),
        .STRIDE (STRIDE),
        .LW     (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .out_wrap  (out_wrap),
        .level     (level)
    );

    typedef struct {
        logic [15:0]   addr;
        logic [LW-1:0] len;
    } entry_t;

    typedef struct {
        logic [15:0] addr;
        logic        last;
        logic        wrap;
    } beat_t;

    entry_t      fifo_m[$];
    beat_t       beats_m[$];
    logic [15:0] held_m;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // A burst is its list of beats: base + i*STRIDE, wrap when the true sum exceeds 16 bits.
    task automatic expand(input entry_t e);
        for (int i = 0; i <= int'(e.len); i++) begin
            int    s;
            beat_t b;
            s      = int'(e.addr) + i * STRIDE;
            b.addr = s[15:0];
            b.last = (i == int'(e.len));
            b.wrap = (s > 65535);
            beats_m.push_back(b);
        end
    endtask

    task automatic model_edge();
        entry_t e;
        int     pre;
        bit     load;
        if (rst) begin
            fifo_m.delete();
            beats_m.delete();
            held_m = '0;
            return;
        end
        pre  = fifo_m.size();
        load = 1'b0;
        if (beats_m.size() == 0) begin
            load = (pre > 0);
        end else if (out_ready) begin
            held_m = beats_m[0].addr;
            void'(beats_m.pop_front());
            load = (beats_m.size() == 0) && (pre > 0);
        end
        if (load) begin
            e = fifo_m.pop_front();
            expand(e);
        end
        if (in_valid && pre < DEPTH) begin
            e.addr = in_addr;
            e.len  = in_len;
            fifo_m.push_back(e);
        end
    endtask

    task automatic compare_outputs();
        check("out_valid", 32'(out_valid), 32'(beats_m.size() != 0));
        check("level", 32'(level), 32'(fifo_m.size()));
        check("in_ready", 32'(in_ready), 32'(fifo_m.size() < DEPTH));
        if (beats_m.size() != 0) begin
            check("out_addr", 32'(out_addr), 32'(beats_m[0].addr));
            check("out_last", 32'(out_last), 32'(beats_m[0].last));
            check("out_wrap", 32'(out_wrap), 32'(beats_m[0].wrap));
        end else begin
            check("out_addr_idle", 32'(out_addr), 32'(held_m));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [LW-1:0] l,
                         input logic r);
        in_valid  = v;
        in_addr   = a;
        in_len    = l;
        out_ready = r;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0000, '0, 1'b0);
        held_m = '0;
        run(2);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_wrap", 32'(out_wrap), 32'd0);
        rst = 1'b0;
        run(1);

        // Single beat with latency check.
        drive(1'b1, 16'h0100, 4'd0, 1'b1);
        tick();
        check("sb_e0_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 16'h0000, 4'd0, 1'b1);
        tick();
        check("sb_e1_valid", 32'(out_valid), 32'd1);
        check("sb_e1_addr", 32'(out_addr), 32'h0100);
        check("sb_e1_last", 32'(out_last), 32'd1);
        tick();
        check("sb_done_valid", 32'(out_valid), 32'd0);
        check("sb_done_level", 32'(level), 32'd0);
        run(2);

        // Four-beat burst, first beat stalled for three cycles.
        drive(1'b1, 16'h1000, 4'd3, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 4'd0, 1'b0);
        tick();
        run(3);
        check("stall_addr", 32'(out_addr), 32'h1000);
        check("stall_last", 32'(out_last), 32'd0);
        out_ready = 1'b1;
        run(6);

        // Wrap past 16'hFFFF.
        drive(1'b1, 16'hFFFE, 4'd3, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 4'd0, 1'b1);
        tick();
        tick();
        tick();
        check("wrap_beat2_addr", 32'(out_addr), 32'h0000);
        check("wrap_beat2_flag", 32'(out_wrap), 32'd1);
        run(4);

        // Fill the FIFO while the output is stalled; the sixth offer is refused.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'(16'h2000 + 16'(i * 16'h0100)), 4'(i % 3), 1'b0);
            tick();
        end
        check("full_level", 32'(level), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b0, 16'h0000, 4'd0, 1'b1);
        run(20);

        // Push on the same edge the head is loaded.
        drive(1'b1, 16'h3000, 4'd1, 1'b1);
        tick();
        drive(1'b1, 16'h3100, 4'd1, 1'b1);
        tick();
        check("simul_level", 32'(level), 32'd1);
        drive(1'b0, 16'h0000, 4'd0, 1'b1);
        run(6);

        // Reset during beat 2 of a 4-beat burst with two entries queued.
        drive(1'b1, 16'h4000, 4'd3, 1'b0);
        tick();
        drive(1'b1, 16'h5000, 4'd3, 1'b0);
        tick();
        drive(1'b1, 16'h6000, 4'd3, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 4'd0, 1'b1);
        tick();
        check("pre_rst_addr", 32'(out_addr), 32'h4001);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_addr", 32'(out_addr), 32'd0);
        rst = 1'b0;
        run(4);
        drive(1'b1, 16'h0100, 4'd0, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 4'd0, 1'b1);
        tick();
        check("post_rst_addr", 32'(out_addr), 32'h0100);
        run(3);

        // Random traffic, including addresses near the top of the space and rare resets.
        for (int i = 0; i < 600; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + 16'($urandom_range(0, 15)))
                                            : 16'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            drive(1'($urandom_range(0, 1)), a, 4'($urandom), 1'($urandom_range(0, 3) != 0));
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 16'h0000, 4'd0, 1'b1);
        run(80);
        check("drain_level", 32'(level), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
